taxi_qsfp_mod_ctrl: RTL and testbench
=====================================

// Module: taxi_qsfp_mod_ctrl
// PURPOSE
// Per-cage QSFP28 module management sequencer. Drives ResetL, LPMode and ModSelL
// from debounced ModPrsL and the config inputs. Sequences each insertion through
// debounce, reset pulse and init wait before declaring the module ready. One
// instance per cage, in the 125 MHz control domain, in place of static tie-offs.
// PARAMETERS
// DEBOUNCE_CYC      125000     cycles ModPrsL must stay low before insertion is accepted
// RESET_ASSERT_CYC  1250       cycles ResetL is held low per reset pulse (10 us @125 MHz)
// INIT_CYC          250000000  cycles after ResetL release before ready (t_init 2 s)
// CNT_W             28         timer width; must hold max(DEBOUNCE_CYC,RESET_ASSERT_CYC,INIT_CYC)
// PORTS
// clk               in   1   control clock
// rst_n             in   1   asynchronous active-low reset
// qsfp_modprsl      in   1   module present, active low, asynchronous
// qsfp_intl         in   1   module interrupt, active low, asynchronous
// qsfp_resetl       out  1   module reset, active low
// qsfp_lpmode       out  1   module low-power mode
// qsfp_modsell      out  1   module select, active low
// cfg_enable        in   1   1 = cage enabled; 0 forces ABSENT
// cfg_lpmode        in   1   LPMode value applied while READY
// cmd_reset         in   1   1-cycle pulse: re-run reset/init
// mod_present       out  1   synchronised presence (ModPrsL low)
// mod_ready         out  1   state == READY
// irq               out  1   1-cycle pulse on IntL assertion while READY
// state             out  3   0 ABSENT,1 DEBOUNCE,2 RESET,3 INIT,4 READY
// stat_insert_count out  16  accepted insertions; saturates at 16'hffff
// BEHAVIOUR
// - Reset (async assert, sync release): state ABSENT, timer 0, resetl 0, lpmode 1, modsell 1,
//   ready 0, irq 0, count 0.
// - modprsl and intl pass through 2-FF synchronisers. All decisions use the synchronised
//   values, so input-to-state latency is 3 cycles.
// - Outputs are registered, Moore-decoded from the next state, and change on the same edge
//   as the state register.
// - ABSENT: resetl 0, lpmode 1, modsell 1. Goes to DEBOUNCE when present && cfg_enable; timer cleared.
// - DEBOUNCE: timer counts up; goes to ABSENT if presence is lost. At timer==DEBOUNCE_CYC-1:
//   goes to RESET, timer cleared, count +1 (saturating).
// - RESET: resetl 0. At timer==RESET_ASSERT_CYC-1: goes to INIT, timer cleared.
// - INIT: resetl 1, lpmode 1, modsell 1. At timer==INIT_CYC-1: goes to READY.
// - READY: resetl 1, modsell 0, lpmode <= cfg_lpmode every cycle (1-cycle latency), mod_ready 1.
// - Priority, evaluated in every state except ABSENT, highest first:
//   1. removal or !cfg_enable -> ABSENT next edge, no debounce on removal.
//   2. cmd_reset (INIT/READY only) -> RESET, timer cleared, count unchanged.
//      cmd_reset is ignored in ABSENT, DEBOUNCE and RESET.
//   3. timer expiry.
// - irq: fires when synchronised IntL goes 1->0 while in READY. A held-low IntL does not
//   refire. A fall in any other state is dropped. If IntL is already low on entry to READY,
//   no pulse is generated.
// - The timer never wraps; it is cleared on every state change.
// TESTING (DEBOUNCE_CYC=8, RESET_ASSERT_CYC=4, INIT_CYC=16)
// 1. modprsl 1->0 at cycle 0:
//    DEBOUNCE at cycle 3, RESET at 11, resetl 0->1 at 15, mod_ready at 31,
//    modsell 0, stat_insert_count 1.
// 2. modprsl low 5 cycles then high:
//    returns to ABSENT, resetl stays 0, count 0; retest with a 7-cycle glitch, same result.
// 3. Removal while READY:
//    within 3 cycles ready 0, resetl 0, lpmode 1, modsell 1, state 0.
// 4. cmd_reset pulse in READY:
//    resetl low exactly 4 cycles, ready again 20 cycles after the pulse +1, count unchanged.
// 5. intl low 10 cycles in READY:
//    exactly one irq pulse 3 cycles after the fall. intl low during INIT: no irq.
// 6. rst_n low mid-INIT:
//    outputs take reset values with no clock. After release with the module present,
//    the full sequence from test 1 repeats and count is 1.

Source files
------------

// File: rtl/taxi_qsfp_mod_ctrl.sv
// QSFP28 per-cage management sequencer: debounces ModPrsL, pulses ResetL,
// waits t_init, then selects the module and forwards LPMode and IntL.
module taxi_qsfp_mod_ctrl #(
  parameter int unsigned DEBOUNCE_CYC     = 125000,
  parameter int unsigned RESET_ASSERT_CYC = 1250,
  parameter int unsigned INIT_CYC         = 250000000,
  parameter int unsigned CNT_W            = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        qsfp_modprsl,
  input  logic        qsfp_intl,
  output logic        qsfp_resetl,
  output logic        qsfp_lpmode,
  output logic        qsfp_modsell,
  input  logic        cfg_enable,
  input  logic        cfg_lpmode,
  input  logic        cmd_reset,
  output logic        mod_present,
  output logic        mod_ready,
  output logic        irq,
  output logic [2:0]  state,
  output logic [15:0] stat_insert_count
);

  typedef enum logic [2:0] {
    ST_ABSENT   = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RESET    = 3'd2,
    ST_INIT     = 3'd3,
    ST_READY    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] INI_LAST = CNT_W'(INIT_CYC - 1);

  logic prs_s1_q, prs_s2_q;
  logic intl_s1_q, intl_s2_q, intl_prev_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [15:0]      count_q, count_d;

  logic resetl_q, lpmode_q, modsell_q;
  logic ready_q, irq_q;
  logic present, lost;

  // Sync FFs reset to the idle (high) level so reset reads as absent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prs_s1_q    <= 1'b1;
      prs_s2_q    <= 1'b1;
      intl_s1_q   <= 1'b1;
      intl_s2_q   <= 1'b1;
      intl_prev_q <= 1'b1;
    end else begin
      prs_s1_q    <= qsfp_modprsl;
      prs_s2_q    <= prs_s1_q;
      intl_s1_q   <= qsfp_intl;
      intl_s2_q   <= intl_s1_q;
      intl_prev_q <= intl_s2_q;
    end
  end

  assign present = !prs_s2_q;
  assign lost    = !present || !cfg_enable;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    unique case (state_q)
      ST_ABSENT: begin
        if (present && cfg_enable) begin
          state_d = ST_DEBOUNCE;
          timer_d = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (lost) begin
          state_d = ST_ABSENT;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = ST_RESET;
          timer_d = '0;
          if (count_q != 16'hffff) count_d = count_q + 16'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESET: begin
        if (lost) begin
          state_d = ST_ABSENT;
          timer_d = '0;
        end else if (timer_q == RST_LAST) begin
          state_d = ST_INIT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_INIT: begin
        if (lost) begin
          state_d = ST_ABSENT;
          timer_d = '0;
        end else if (cmd_reset) begin
          state_d = ST_RESET;
          timer_d = '0;
        end else if (timer_q == INI_LAST) begin
          state_d = ST_READY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_READY: begin
        if (lost) begin
          state_d = ST_ABSENT;
          timer_d = '0;
        end else if (cmd_reset) begin
          state_d = ST_RESET;
          timer_d = '0;
        end
      end
      default: begin
        state_d = ST_ABSENT;
        timer_d = '0;
      end
    endcase
  end

  // Module pins are decoded from the next state so they move with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ABSENT;
      timer_q   <= '0;
      count_q   <= '0;
      resetl_q  <= 1'b0;
      lpmode_q  <= 1'b1;
      modsell_q <= 1'b1;
      ready_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      resetl_q  <= (state_d == ST_INIT) || (state_d == ST_READY);
      lpmode_q  <= (state_d == ST_READY) ? cfg_lpmode : 1'b1;
      modsell_q <= (state_d != ST_READY);
      ready_q   <= (state_d == ST_READY);
      irq_q     <= (state_q == ST_READY) && intl_prev_q && !intl_s2_q;
    end
  end

  assign qsfp_resetl       = resetl_q;
  assign qsfp_lpmode       = lpmode_q;
  assign qsfp_modsell      = modsell_q;
  assign mod_present       = present;
  assign mod_ready         = ready_q;
  assign irq               = irq_q;
  assign state             = state_q;
  assign stat_insert_count = count_q;

endmodule

// File: tb/tb_taxi_qsfp_mod_ctrl.sv
// Directed bench for taxi_qsfp_mod_ctrl with short timers.
// Index i in the capture arrays is the value just after the i-th edge.
module tb_taxi_qsfp_mod_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        qsfp_modprsl = 1'b1;
  logic        qsfp_intl = 1'b1;
  logic        qsfp_resetl, qsfp_lpmode, qsfp_modsell;
  logic        cfg_enable = 1'b1;
  logic        cfg_lpmode = 1'b0;
  logic        cmd_reset = 1'b0;
  logic        mod_present, mod_ready, irq;
  logic [2:0]  state;
  logic [15:0] stat_insert_count;

  int total = 0;
  int bad = 0;

  logic [2:0]  st [0:40];
  logic        rl [0:40];
  logic        rd [0:40];
  logic        ms [0:40];
  logic        lp [0:40];
  logic        ir [0:40];
  logic [15:0] cn [0:40];

  taxi_qsfp_mod_ctrl #(
    .DEBOUNCE_CYC(8),
    .RESET_ASSERT_CYC(4),
    .INIT_CYC(16),
    .CNT_W(28)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .qsfp_modprsl(qsfp_modprsl),
    .qsfp_intl(qsfp_intl),
    .qsfp_resetl(qsfp_resetl),
    .qsfp_lpmode(qsfp_lpmode),
    .qsfp_modsell(qsfp_modsell),
    .cfg_enable(cfg_enable),
    .cfg_lpmode(cfg_lpmode),
    .cmd_reset(cmd_reset),
    .mod_present(mod_present),
    .mod_ready(mod_ready),
    .irq(irq),
    .state(state),
    .stat_insert_count(stat_insert_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int i);
    tick();
    st[i] = state;
    rl[i] = qsfp_resetl;
    rd[i] = mod_ready;
    ms[i] = qsfp_modsell;
    lp[i] = qsfp_lpmode;
    ir[i] = irq;
    cn[i] = stat_insert_count;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    total++;
    if ({state, qsfp_resetl, qsfp_lpmode, qsfp_modsell} !== 6'b000_011) begin
      bad++;
      $display("FAIL reset_pins got st=%0d rl=%b lp=%b ms=%b want 0 0 1 1",
               state, qsfp_resetl, qsfp_lpmode, qsfp_modsell);
    end
    total++;
    if ({mod_ready, irq, mod_present} !== 3'b000 || stat_insert_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_stat got rd=%b irq=%b pr=%b cnt=%0d want 0 0 0 0",
               mod_ready, irq, mod_present, stat_insert_count);
    end
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_glitch();
    int lens [2] = '{5, 7};
    for (int k = 0; k < 2; k++) begin
      int len;
      logic rl_hi;
      logic saw_rst;
      len = lens[k];
      rl_hi = 1'b0;
      saw_rst = 1'b0;
      qsfp_modprsl = 1'b0;
      for (int i = 1; i <= 14; i++) begin
        step(i);
        if (i == len) qsfp_modprsl = 1'b1;
        if (rl[i]) rl_hi = 1'b1;
        if (st[i] == 3'd2) saw_rst = 1'b1;
      end
      total++;
      if (st[len+2] !== 3'd1) begin
        bad++;
        $display("FAIL glitch%0d_debounce got=%0d want=1", len, st[len+2]);
      end
      total++;
      if (st[len+3] !== 3'd0) begin
        bad++;
        $display("FAIL glitch%0d_absent got=%0d want=0", len, st[len+3]);
      end
      total++;
      if (rl_hi !== 1'b0 || saw_rst !== 1'b0) begin
        bad++;
        $display("FAIL glitch%0d_noreset got rl_hi=%b saw=%b want 0 0",
                 len, rl_hi, saw_rst);
      end
      total++;
      if (stat_insert_count !== 16'd0) begin
        bad++;
        $display("FAIL glitch%0d_count got=%0d want=0", len, stat_insert_count);
      end
    end
  endtask

  task automatic test_insert();
    qsfp_modprsl = 1'b0;
    for (int i = 1; i <= 32; i++) step(i);
    total++;
    if (st[2] !== 3'd0 || st[3] !== 3'd1) begin
      bad++;
      $display("FAIL ins_debounce got st2=%0d st3=%0d want 0 1", st[2], st[3]);
    end
    total++;
    if (st[10] !== 3'd1 || st[11] !== 3'd2) begin
      bad++;
      $display("FAIL ins_reset got st10=%0d st11=%0d want 1 2", st[10], st[11]);
    end
    total++;
    if (rl[14] !== 1'b0 || rl[15] !== 1'b1 || st[15] !== 3'd3) begin
      bad++;
      $display("FAIL ins_resetl got rl14=%b rl15=%b st15=%0d want 0 1 3",
               rl[14], rl[15], st[15]);
    end
    total++;
    if (rd[30] !== 1'b0 || rd[31] !== 1'b1 || st[31] !== 3'd4) begin
      bad++;
      $display("FAIL ins_ready got rd30=%b rd31=%b st31=%0d want 0 1 4",
               rd[30], rd[31], st[31]);
    end
    total++;
    if (ms[30] !== 1'b1 || ms[31] !== 1'b0 || lp[30] !== 1'b1 || lp[31] !== 1'b0) begin
      bad++;
      $display("FAIL ins_modsel got ms30=%b ms31=%b lp30=%b lp31=%b want 1 0 1 0",
               ms[30], ms[31], lp[30], lp[31]);
    end
    total++;
    if (cn[10] !== 16'd0 || cn[11] !== 16'd1 || cn[32] !== 16'd1) begin
      bad++;
      $display("FAIL ins_count got c10=%0d c11=%0d c32=%0d want 0 1 1",
               cn[10], cn[11], cn[32]);
    end
    total++;
    if (mod_present !== 1'b1) begin
      bad++;
      $display("FAIL ins_present got=%b want=1", mod_present);
    end
  endtask

  task automatic test_lpmode();
    cfg_lpmode = 1'b1;
    tick();
    total++;
    if (qsfp_lpmode !== 1'b1) begin
      bad++;
      $display("FAIL lpmode_set got=%b want=1", qsfp_lpmode);
    end
    cfg_lpmode = 1'b0;
    tick();
    total++;
    if (qsfp_lpmode !== 1'b0) begin
      bad++;
      $display("FAIL lpmode_clr got=%b want=0", qsfp_lpmode);
    end
  endtask

  task automatic test_irq();
    int n;
    n = 0;
    qsfp_intl = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(i);
      if (i == 10) qsfp_intl = 1'b1;
      if (ir[i]) n++;
    end
    total++;
    if (ir[2] !== 1'b0 || ir[3] !== 1'b1) begin
      bad++;
      $display("FAIL irq_timing got ir2=%b ir3=%b want 0 1", ir[2], ir[3]);
    end
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL irq_count got=%0d want=1", n);
    end
  endtask

  task automatic test_cmd_reset();
    int lo;
    int n;
    lo = 0;
    n = 0;
    cmd_reset = 1'b1;
    step(1);
    cmd_reset = 1'b0;
    for (int i = 2; i <= 26; i++) begin
      step(i);
      if (i == 6) qsfp_intl = 1'b0;
    end
    for (int i = 1; i <= 26; i++) begin
      if (!rl[i]) lo++;
      if (ir[i]) n++;
    end
    total++;
    if (lo != 4 || rl[1] !== 1'b0 || rl[5] !== 1'b1) begin
      bad++;
      $display("FAIL cmd_resetl got lo=%0d rl1=%b rl5=%b want 4 0 1", lo, rl[1], rl[5]);
    end
    total++;
    if (rd[20] !== 1'b0 || rd[21] !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready got rd20=%b rd21=%b want 0 1", rd[20], rd[21]);
    end
    total++;
    if (cn[21] !== 16'd1) begin
      bad++;
      $display("FAIL cmd_count got=%0d want=1", cn[21]);
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL irq_init_drop got=%0d want=0", n);
    end
    qsfp_intl = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_removal();
    qsfp_modprsl = 1'b1;
    for (int i = 1; i <= 3; i++) step(i);
    total++;
    if (st[2] !== 3'd4 || rd[2] !== 1'b1) begin
      bad++;
      $display("FAIL rem_hold got st2=%0d rd2=%b want 4 1", st[2], rd[2]);
    end
    total++;
    if ({st[3], rd[3], rl[3], lp[3], ms[3]} !== 7'b000_0011) begin
      bad++;
      $display("FAIL rem_absent got st=%0d rd=%b rl=%b lp=%b ms=%b want 0 0 0 1 1",
               st[3], rd[3], rl[3], lp[3], ms[3]);
    end
  endtask

  task automatic test_reset_mid_init();
    repeat (4) tick();
    qsfp_modprsl = 1'b0;
    for (int i = 1; i <= 20; i++) step(i);
    total++;
    if (st[20] !== 3'd3) begin
      bad++;
      $display("FAIL mid_init_pre got=%0d want=3", st[20]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({state, qsfp_resetl, qsfp_lpmode, qsfp_modsell, mod_ready} !== 7'b000_0110
        || stat_insert_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_init_async got st=%0d rl=%b lp=%b ms=%b rd=%b cnt=%0d want 0 0 1 1 0 0",
               state, qsfp_resetl, qsfp_lpmode, qsfp_modsell, mod_ready, stat_insert_count);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) step(i);
    total++;
    if (st[2] !== 3'd0 || st[3] !== 3'd1 || st[11] !== 3'd2) begin
      bad++;
      $display("FAIL rerun_states got st2=%0d st3=%0d st11=%0d want 0 1 2",
               st[2], st[3], st[11]);
    end
    total++;
    if (rl[14] !== 1'b0 || rl[15] !== 1'b1 || rd[30] !== 1'b0 || rd[31] !== 1'b1) begin
      bad++;
      $display("FAIL rerun_ready got rl14=%b rl15=%b rd30=%b rd31=%b want 0 1 0 1",
               rl[14], rl[15], rd[30], rd[31]);
    end
    total++;
    if (cn[31] !== 16'd1) begin
      bad++;
      $display("FAIL rerun_count got=%0d want=1", cn[31]);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    repeat (4) tick();
    test_insert();
    test_lpmode();
    test_irq();
    test_cmd_reset();
    test_removal();
    test_reset_mid_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
